seg7_mux_driver: RTL and testbench
==================================

Name: seg7_mux_driver

Overview:
- Parametrised, time-multiplexed hexadecimal seven-segment display driver for N common-anode digits.
- Successor to the single-segment combinational decoders. Decodes all seven segments from one shared decoder, scans the digits with a prescaled refresh counter, and inserts a one-cycle anode dead-time between digits to suppress ghosting.
- Provides load-strobed shadow registers, per-digit enable, decimal points and leading-zero blanking.
- Sits between datapath or status logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot including the dead cycle; must be >= 2.
- IDX_W, max(1,$clog2(N_DIGITS)), derived; width of the digit index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*N_DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is the rightmost and least significant.
- load  in  1  when 1 at a rising edge, captures value, dp_in and en into the shadow registers.
- dp_in  in  N_DIGITS  decimal point request per digit, active-high.
- en  in  N_DIGITS  digit enable per digit, active-high.
- blank_lz  in  1  leading-zero blanking mode; sampled live, not latched.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  N_DIGITS  digit anodes, active-low, one-hot-low or all-high.
- digit_idx  out  IDX_W  index of the digit currently in its slot.
- frame_done  out  1  one-cycle pulse when digit_idx wraps from N_DIGITS-1 to 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: value_q=0, dp_q=0, en_q=0, cnt=0, digit_idx=0, frame_done=0, an=all-ones, seg=7'h7F, dp=1.
- Shadow registers: on load=1, value_q/dp_q/en_q <= value/dp_in/en. Otherwise they hold.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (cnt==REFRESH_DIV-1).
- Index on tick: digit_idx <= (digit_idx==N_DIGITS-1) ? 0 : digit_idx+1, and frame_done <= (digit_idx==N_DIGITS-1). frame_done is 0 in all other cycles.
- Dead-time: all of seg/dp/an are registered. In the cycle after a tick edge, an=all-ones, seg=7'h7F, dp=1.
- Normal output, every other cycle, for i = digit_idx:
  - lit_i = en_q[i] AND NOT lz_i.
  - an = lit_i ? ~(1<<i) : all-ones.
  - seg = lit_i ? DEC(value_q nibble i) : 7'h7F.
  - dp = ~(lit_i AND dp_q[i]).
- Leading-zero blanking: lz_i = blank_lz AND (i != 0) AND (nibbles i..N_DIGITS-1 of value_q are all 0). Digit 0 is never blanked by lz.
- DEC table (active-low hex), 0..F:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Latency: load at edge t, value_q updates at t, outputs reflect it from edge t+1 (when digit_idx already selects the digit and the cycle is not dead-time).
- Slot timing: after each tick the slot is 1 dead cycle followed by REFRESH_DIV-1 lit cycles.
- N_DIGITS=1: digit_idx stays 0; frame_done pulses on every tick; dead cycle still inserted.
- Simultaneous load and tick: both take effect at the same edge. The output for that edge is dead-time, and the next cycle shows the new data on the new digit.
- Reset mid-scan: everything returns to reset values at the next edge. load during reset is ignored.

Test Plan:
- N=4, DIV=4. Reset 3 cycles, then load value=16'h12AF, en=4'hF, dp_in=0 -> on lit cycles of idx0: an=4'b1110, seg=7'h0E. idx1: an=4'b1101, seg=7'h08. idx2: an=4'b1011, seg=7'h24. idx3: an=4'b0111, seg=7'h79. Exactly one dead cycle (an=4'hF, seg=7'h7F) after each tick. frame_done high only on the cycle idx returns to 0.
- Load value=16'h0005, blank_lz=1, en=4'hF -> digits 3,2,1 show an=4'hF/seg=7'h7F; digit 0 shows seg=7'h12. Set blank_lz=0 -> digits 3..1 show seg=7'h40.
- Value=16'h0000, blank_lz=1 -> digit 0 shows seg=7'h40; digits 1..3 blanked.
- en=4'b0101, dp_in=4'b0001 -> an never drives digits 1 or 3 low. dp=0 only during digit 0 lit cycles.
- Apply load=1 in the same cycle as a tick with a new value -> dead cycle first, then the new nibble on the next digit. Assert reset mid-slot -> next cycle an=4'hF, seg=7'h7F, digit_idx=0, cnt=0.
- Exhaustive decode: N=1, DIV=2, load nibbles 0..F in sequence -> seg matches the DEC table for each value.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed hex seven-segment driver for N common-anode digits.
// One shared decoder, prescaled digit scan, one dead cycle per slot, leading-zero blanking.
module seg7_mux_driver #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   en,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);
    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Active-low hex font, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] dec7(input logic [3:0] nib);
        case (nib)
            4'h0:    dec7 = 7'h40;
            4'h1:    dec7 = 7'h79;
            4'h2:    dec7 = 7'h24;
            4'h3:    dec7 = 7'h30;
            4'h4:    dec7 = 7'h19;
            4'h5:    dec7 = 7'h12;
            4'h6:    dec7 = 7'h02;
            4'h7:    dec7 = 7'h78;
            4'h8:    dec7 = 7'h00;
            4'h9:    dec7 = 7'h10;
            4'hA:    dec7 = 7'h08;
            4'hB:    dec7 = 7'h03;
            4'hC:    dec7 = 7'h46;
            4'hD:    dec7 = 7'h21;
            4'hE:    dec7 = 7'h06;
            4'hF:    dec7 = 7'h0E;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   en_q, en_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  frame_done_q, frame_done_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_pin_q, dp_pin_d;

    logic                  tick_s;
    logic                  zacc_s;
    logic [N_DIGITS-1:0]   zero_tail_s;
    logic [N_DIGITS-1:0]   lz_s;
    logic [N_DIGITS-1:0]   onehot_s;
    logic [3:0]            sel_nib_s;
    logic                  lit_s;
    logic                  sel_dp_s;

    // Shadow register capture on load strobe.
    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        en_d    = en_q;
        if (load) begin
            value_d = value;
            dp_d    = dp_in;
            en_d    = en;
        end else begin
            value_d = value_q;
            dp_d    = dp_q;
            en_d    = en_q;
        end
    end

    // Refresh prescaler and digit index advance.
    always_comb begin
        tick_s       = (cnt_q == CNT_LAST);
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (tick_s) begin
            cnt_d        = CNT_W'(0);
            frame_done_d = (idx_q == IDX_LAST);
            idx_d        = (idx_q == IDX_LAST) ? IDX_W'(0) : idx_q + IDX_W'(1);
        end else begin
            cnt_d        = cnt_q + CNT_W'(1);
        end
    end

    // zero_tail_s[i] is set when nibbles i..N_DIGITS-1 are all zero.
    always_comb begin
        zacc_s      = 1'b1;
        zero_tail_s = {N_DIGITS{1'b0}};
        lz_s        = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zacc_s         = zacc_s & (value_q[4*i +: 4] == 4'h0);
            zero_tail_s[i] = zacc_s;
            lz_s[i]        = blank_lz & zero_tail_s[i] & ((i != 0) ? 1'b1 : 1'b0);
        end
    end

    // Digit select and registered pin values; the tick edge forces the dead cycle.
    always_comb begin
        onehot_s  = {N_DIGITS{1'b0}};
        sel_nib_s = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            onehot_s[i] = (idx_q == IDX_W'(i));
            sel_nib_s   = sel_nib_s | (value_q[4*i +: 4] & {4{onehot_s[i]}});
        end
        lit_s    = |(onehot_s & en_q & ~lz_s);
        sel_dp_s = |(onehot_s & dp_q);
        an_d     = {N_DIGITS{1'b1}};
        seg_d    = 7'h7F;
        dp_pin_d = 1'b1;
        if (tick_s || !lit_s) begin
            an_d     = {N_DIGITS{1'b1}};
            seg_d    = 7'h7F;
            dp_pin_d = 1'b1;
        end else begin
            an_d     = ~onehot_s;
            seg_d    = dec7(sel_nib_s);
            dp_pin_d = ~sel_dp_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= {(4*N_DIGITS){1'b0}};
            dp_q         <= {N_DIGITS{1'b0}};
            en_q         <= {N_DIGITS{1'b0}};
            cnt_q        <= CNT_W'(0);
            idx_q        <= IDX_W'(0);
            frame_done_q <= 1'b0;
            an_q         <= {N_DIGITS{1'b1}};
            seg_q        <= 7'h7F;
            dp_pin_q     <= 1'b1;
        end else begin
            value_q      <= value_d;
            dp_q         <= dp_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_pin_q     <= dp_pin_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_pin_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: instance A (N=4, DIV=4) and instance B (N=1, DIV=2).
module tb_seg7_mux_driver;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, load_a = 1'b0, blz_a = 1'b0;
    logic [15:0] value_a = 16'h0;
    logic [3:0]  dp_in_a = 4'h0, en_a = 4'h0;
    logic [6:0]  seg_a;
    logic        dp_a, fd_a;
    logic [3:0]  an_a;
    logic [1:0]  idx_a;

    logic        rst_b = 1'b1, load_b = 1'b0, blz_b = 1'b0;
    logic [3:0]  value_b = 4'h0;
    logic        dp_in_b = 1'b0, en_b = 1'b0;
    logic [6:0]  seg_b;
    logic        dp_b, fd_b, an_b, idx_b;

    seg7_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .value(value_a), .load(load_a), .dp_in(dp_in_a),
        .en(en_a), .blank_lz(blz_a), .seg(seg_a), .dp(dp_a), .an(an_a),
        .digit_idx(idx_a), .frame_done(fd_a));

    seg7_mux_driver #(.N_DIGITS(1), .REFRESH_DIV(2)) dut_b (
        .clk(clk), .reset(rst_b), .value(value_b), .load(load_b), .dp_in(dp_in_b),
        .en(en_b), .blank_lz(blz_b), .seg(seg_b), .dp(dp_b), .an(an_b),
        .digit_idx(idx_b), .frame_done(fd_b));

    int tests = 0;
    int failed = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Bench-side scan position and expected per-digit appearance (hand-computed tables).
    int               m_cnt [2];
    int               m_idx [2];
    logic [3:0][6:0]  t_seg [2];
    logic [3:0]       t_lit [2];
    logic [3:0]       t_dp  [2];
    logic [3:0][6:0]  n_seg [2];
    logic [3:0]       n_lit [2];
    logic [3:0]       n_dp  [2];

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic exp_t predict(input logic rst, input int cnt, input int idx,
                                     input int n, input int div, input logic [3:0][6:0] sg,
                                     input logic [3:0] lt, input logic [3:0] dpt);
        exp_t e;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 2'd0; e.fd = 1'b0;
        if (!rst) begin
            if (cnt == div - 1) begin
                e.idx = (idx == n - 1) ? 2'd0 : 2'(idx + 1);
                e.fd  = (idx == n - 1);
            end else begin
                e.idx = 2'(idx);
                if (lt[idx]) begin
                    e.an  = ~(4'b0001 << idx);
                    e.seg = sg[idx];
                    e.dp  = ~dpt[idx];
                end
            end
        end
        return e;
    endfunction

    task automatic step(input int k);
        exp_t e;
        logic r, ld;
        int n, div;
        r   = (k == 0) ? rst_a : rst_b;
        ld  = (k == 0) ? load_a : load_b;
        n   = (k == 0) ? 4 : 1;
        div = (k == 0) ? 4 : 2;
        e = predict(r, m_cnt[k], m_idx[k], n, div, t_seg[k], t_lit[k], t_dp[k]);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt[k] = 0; m_idx[k] = 0; t_lit[k] = 4'h0; t_dp[k] = 4'h0;
        end else begin
            if (m_cnt[k] == div - 1) begin
                m_cnt[k] = 0;
                m_idx[k] = (m_idx[k] == n - 1) ? 0 : m_idx[k] + 1;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
            end
            if (ld) begin
                t_seg[k] = n_seg[k]; t_lit[k] = n_lit[k]; t_dp[k] = n_dp[k];
            end
        end
    endtask

    task automatic run(input int k, input int cycles);
        repeat (cycles) step(k);
    endtask

    task automatic pulse_load_a();
        load_a = 1'b1; step(0); load_a = 1'b0;
    endtask

    // Monitor for instance A.
    always @(posedge clk) begin
        exp_t e, act;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            act = {an_a, seg_a, dp_a, idx_a, fd_a};
            tests++;
            if (act !== e) begin
                failed++;
                $display("FAIL out_a t=%0t actual an=%b seg=%h dp=%b idx=%0d fd=%b required an=%b seg=%h dp=%b idx=%0d fd=%b",
                         $time, act.an, act.seg, act.dp, act.idx, act.fd, e.an, e.seg, e.dp, e.idx, e.fd);
            end
        end
    end

    // Monitor for instance B.
    always @(posedge clk) begin
        exp_t e, act;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            act = {3'b111, an_b, seg_b, dp_b, 1'b0, idx_b, fd_b};
            tests++;
            if (act !== e) begin
                failed++;
                $display("FAIL out_b t=%0t actual an=%b seg=%h dp=%b idx=%0d fd=%b required an=%b seg=%h dp=%b idx=%0d fd=%b",
                         $time, act.an, act.seg, act.dp, act.idx, act.fd, e.an, e.seg, e.dp, e.idx, e.fd);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual still running required finished", $time);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_idx[k] = 0;
            t_seg[k] = '0; t_lit[k] = 4'h0; t_dp[k] = 4'h0;
            n_seg[k] = '0; n_lit[k] = 4'h0; n_dp[k] = 4'h0;
        end
        fork
            begin : stim_a
                // Reset, with a load attempt that must be ignored.
                run(0, 2);
                load_a = 1'b1; value_a = 16'hFFFF; en_a = 4'hF; step(0); load_a = 1'b0;
                rst_a = 1'b0;
                // 12AF, all digits on.
                value_a = 16'h12AF; en_a = 4'hF; dp_in_a = 4'h0; blz_a = 1'b0;
                n_seg[0] = {7'h79, 7'h24, 7'h08, 7'h0E}; n_lit[0] = 4'hF; n_dp[0] = 4'h0;
                pulse_load_a();
                run(0, 40);
                // 0005 with blanking (old 12AF has no leading zeros, so current view unchanged).
                value_a = 16'h0005; blz_a = 1'b1;
                n_seg[0] = {7'h7F, 7'h7F, 7'h7F, 7'h12}; n_lit[0] = 4'b0001; n_dp[0] = 4'h0;
                pulse_load_a();
                run(0, 32);
                // Blanking off, live.
                blz_a = 1'b0;
                t_seg[0] = {7'h40, 7'h40, 7'h40, 7'h12}; t_lit[0] = 4'hF;
                run(0, 32);
                // 0000 with blanking; blanking of old 0005 applies immediately.
                blz_a = 1'b1;
                t_seg[0] = {7'h7F, 7'h7F, 7'h7F, 7'h12}; t_lit[0] = 4'b0001;
                value_a = 16'h0000;
                n_seg[0] = {7'h7F, 7'h7F, 7'h7F, 7'h40}; n_lit[0] = 4'b0001; n_dp[0] = 4'h0;
                pulse_load_a();
                run(0, 32);
                // Partial enable with decimal point; blanking off shows old 0000 fully.
                blz_a = 1'b0;
                t_seg[0] = {7'h40, 7'h40, 7'h40, 7'h40}; t_lit[0] = 4'hF;
                value_a = 16'h12AF; en_a = 4'b0101; dp_in_a = 4'b0001;
                n_seg[0] = {7'h79, 7'h24, 7'h08, 7'h0E}; n_lit[0] = 4'b0101; n_dp[0] = 4'b0001;
                pulse_load_a();
                run(0, 32);
                // Load coinciding with a tick.
                while (m_cnt[0] != 3) step(0);
                value_a = 16'h3456; en_a = 4'hF; dp_in_a = 4'h0;
                n_seg[0] = {7'h30, 7'h19, 7'h12, 7'h02}; n_lit[0] = 4'hF; n_dp[0] = 4'h0;
                pulse_load_a();
                run(0, 9);
                // Reset mid-slot.
                while (m_cnt[0] != 1) step(0);
                rst_a = 1'b1; step(0); rst_a = 1'b0;
                run(0, 12);
            end
            begin : stim_b
                run(1, 2);
                rst_b = 1'b0; blz_b = 1'b1;
                for (int v = 0; v < 16; v++) begin
                    logic [3:0] vb;
                    vb = 4'(v);
                    value_b = vb; en_b = 1'b1; dp_in_b = vb[0];
                    n_seg[1] = {7'h7F, 7'h7F, 7'h7F, dec_tbl[v]};
                    n_lit[1] = 4'b0001; n_dp[1] = {3'b000, vb[0]};
                    load_b = 1'b1; step(1); load_b = 1'b0;
                    run(1, 3);
                end
            end
        join
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failed++;
            $display("FAIL drain actual q0=%0d q1=%0d required 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
